// File: rtl/shift_mode_seq.sv
// rtl/shift_mode_seq.sv - command sequencer driving the shift-mode select mux and shift enable
// Accepts {mode, count} commands, validates mode, then issues count shift_en cycles.
module shift_mode_seq #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_mode,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             abort,
  output logic [2:0]       sel,
  output logic             shift_en,
  output logic             busy,
  output logic [CNT_W-1:0] remaining,
  output logic             done,
  output logic             err,
  output logic             aborted
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [2:0]       MODE_MAX = 3'b100;
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t state;
  logic   accept;
  logic   mode_legal;
  logic   last_shift;

  assign cmd_ready  = (state == IDLE);
  assign busy       = (state == RUN);
  assign accept     = cmd_valid && cmd_ready;
  assign mode_legal = (cmd_mode <= MODE_MAX);
  assign last_shift = (remaining == CNT_ONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      sel       <= 3'b000;
      shift_en  <= 1'b0;
      remaining <= CNT_ZERO;
      done      <= 1'b0;
      err       <= 1'b0;
      aborted   <= 1'b0;
    end else begin
      done    <= 1'b0;
      err     <= 1'b0;
      aborted <= 1'b0;
      case (state)
        IDLE: begin
          // abort is deliberately ignored here, even on an accepting edge
          if (accept) begin
            if (!mode_legal) begin
              err <= 1'b1;
            end else begin
              sel <= cmd_mode;
              if (cmd_count == CNT_ZERO) begin
                done <= 1'b1;
              end else begin
                remaining <= cmd_count;
                shift_en  <= 1'b1;
                state     <= RUN;
              end
            end
          end
        end
        RUN: begin
          // completion takes priority over a coincident abort on the final shift
          if (last_shift) begin
            shift_en  <= 1'b0;
            remaining <= CNT_ZERO;
            done      <= 1'b1;
            state     <= IDLE;
          end else if (abort) begin
            shift_en  <= 1'b0;
            remaining <= CNT_ZERO;
            aborted   <= 1'b1;
            state     <= IDLE;
          end else begin
            remaining <= remaining - CNT_ONE;
          end
        end
        default: begin
          state    <= IDLE;
          shift_en <= 1'b0;
        end
      endcase
    end
  end

endmodule
